// File: rtl/font_text_sequencer.sv
// Character FIFO plus cursor FSM that issues one add_fnt command per glyph.
// Define FONT_WRAP_EN to wrap glyphs at the right edge back to the margin.
`timescale 1ns/1ps
module font_text_sequencer #(
    parameter int DEPTH    = 32,
    parameter int CHAR_GAP = 1,
    parameter int LINE_GAP = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [5:0]               push_char,
    input  logic                     start,
    input  logic [9:0]               x_start,
    input  logic [8:0]               y_start,
    input  logic                     bmp_busy,
    output logic                     add_fnt,
    output logic [5:0]               fnt_indx,
    output logic [9:0]               xloc,
    output logic [8:0]               yloc,
    output logic                     busy,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     done,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [9:0] X_PITCH = 10'(13 + CHAR_GAP);
    localparam logic [8:0] Y_PITCH = 9'(16 + LINE_GAP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_HOLD,
        S_WAIT
    } state_t;

    logic [5:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic [5:0]    head;
    logic          pop;
    logic          pop_ok;
    logic          push_ok;

    state_t     state, state_n;
    logic [9:0] x_cur, x_n;
    logic [8:0] y_cur, y_n;
    logic [9:0] margin, margin_n;
    logic       ovf_q, ovf_n;
    logic       add_c;
    logic       done_c;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    assign pop_ok  = pop && !empty;
    // A full FIFO still accepts a push when the same cycle pops.
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_char;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)
                cnt <= cnt + 1'b1;
            else if (!push_ok && pop_ok)
                cnt <= cnt - 1'b1;
        end
    end

    logic [10:0] x_sum;
    logic [9:0]  y_sum;
    logic [9:0]  x_adv;
    logic [8:0]  y_adv;
    logic        x_fits;
    logic        y_fits;
    logic        is_nl;
    logic        is_sp;
    logic        is_bad;

    // Cursor advances saturate so a tall y can never wrap back to row 0.
    assign x_sum  = {1'b0, x_cur} + {1'b0, X_PITCH};
    assign y_sum  = {1'b0, y_cur} + {1'b0, Y_PITCH};
    assign x_adv  = x_sum[10] ? 10'h3ff : x_sum[9:0];
    assign y_adv  = y_sum[9] ? 9'h1ff : y_sum[8:0];
    assign x_fits = ({1'b0, x_cur} + 11'd13) <= 11'd640;
    assign y_fits = ({1'b0, y_cur} + 10'd16) <= 10'd480;
    assign is_nl  = (head == 6'd63);
    assign is_sp  = (head == 6'd42);
    assign is_bad = (head > 6'd42);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            x_cur  <= '0;
            y_cur  <= '0;
            margin <= '0;
            ovf_q  <= 1'b0;
        end else begin
            state  <= state_n;
            x_cur  <= x_n;
            y_cur  <= y_n;
            margin <= margin_n;
            ovf_q  <= ovf_n;
        end
    end

    always_comb begin
        state_n  = state;
        x_n      = x_cur;
        y_n      = y_cur;
        margin_n = margin;
        ovf_n    = ovf_q;
        pop      = 1'b0;
        add_c    = 1'b0;
        done_c   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    x_n      = x_start;
                    y_n      = y_start;
                    margin_n = x_start;
                    ovf_n    = 1'b0;
                    state_n  = S_FETCH;
                end
            end
            S_FETCH: begin
                if (empty) begin
                    done_c  = 1'b1;
                    state_n = S_IDLE;
                end else if (is_nl) begin
                    pop = 1'b1;
                    x_n = margin;
                    y_n = y_adv;
                end else if (is_sp) begin
                    pop = 1'b1;
                    x_n = x_adv;
                end else if (is_bad) begin
                    pop = 1'b1;
                end else if (!x_fits) begin
`ifdef FONT_WRAP_EN
                    if (x_cur != margin) begin
                        x_n = margin;
                        y_n = y_adv;
                    end else begin
                        pop   = 1'b1;
                        ovf_n = 1'b1;
                    end
`else
                    pop   = 1'b1;
                    ovf_n = 1'b1;
`endif
                end else if (!y_fits) begin
                    pop   = 1'b1;
                    ovf_n = 1'b1;
                end else if (!bmp_busy) begin
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE: begin
                add_c   = 1'b1;
                pop     = 1'b1;
                state_n = S_HOLD;
            end
            S_HOLD: begin
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (!bmp_busy) begin
                    x_n     = x_adv;
                    state_n = S_FETCH;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign add_fnt  = add_c;
    assign fnt_indx = add_c ? head : 6'd0;
    assign xloc     = x_cur;
    assign yloc     = y_cur;
    assign busy     = (state != S_IDLE);
    assign done     = done_c;
    assign overflow = ovf_q;

endmodule
